// File: rtl/tlb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : tlb_pkg                                                    |
// | Description : Shared types for the set-associative TLB: PTE permission   |
// |               bits, controller state encoding and the stored entry.      |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package tlb_pkg;

    // Storage widths of a TLB entry; sized for Sv48 (36-bit VPN, 44-bit PPN).
    // Instances with narrower VPN/PPN parameters zero-extend into these.
    localparam int TLB_VPN_W = 36;
    localparam int TLB_PPN_W = 44;

    // PTE permission/attribute bits in RISC-V PTE bit order (bit 7 .. bit 0).
    typedef struct packed {
        logic d;
        logic a;
        logic g;
        logic u;
        logic x;
        logic w;
        logic r;
        logic v;
    } tlb_perm_bits;

    // Miss-handling controller state.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } tlb_state_e;

    // One translation held in a way of a set.
    typedef struct packed {
        logic                 valid;
        logic [TLB_VPN_W-1:0] tag;
        logic [TLB_PPN_W-1:0] ppn;
        tlb_perm_bits         perm;
    } tlb_entry_t;

endpackage : tlb_pkg
`default_nettype wire

// File: rtl/tlb_set_lookup.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tlb_set_lookup                                             |
// | Description : Combinational tag compare across all ways of one set with  |
// |               lowest-way priority; returns hit, way index and entry.     |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tlb_set_lookup
    import tlb_pkg::*;
#(
    parameter int WAYS  = 4,
    parameter int WAY_W = 2
) (
    input  tlb_entry_t           entries [WAYS],
    input  logic [TLB_VPN_W-1:0] tag,
    output logic                 hit,
    output logic [WAY_W-1:0]     way,
    output tlb_entry_t           entry
);

    // Scan from the top way down so the lowest matching way is the one that sticks
    always_comb begin
        hit   = 1'b0;
        way   = '0;
        entry = entries[0];
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (entries[i].valid && (entries[i].tag == tag)) begin
                hit   = 1'b1;
                way   = WAY_W'(i);
                entry = entries[i];
            end
        end
    end

endmodule : tlb_set_lookup
`default_nettype wire

// File: rtl/set_assoc_tlb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : set_assoc_tlb                                              |
// | Description : N-way set-associative TLB with combinational hit lookup,   |
// |               one outstanding MMU miss request, per-set round-robin      |
// |               replacement and full / selective invalidation.             |
// |               Macro TLB_FLUSH_VA_EN: when defined, flush_va_valid only   |
// |               invalidates ways in set(flush_va) whose tag matches; when  |
// |               undefined, flush_va_valid acts as a full flush.            |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module set_assoc_tlb
    import tlb_pkg::*;
#(
    parameter int WAYS         = 4,
    parameter int SETS         = 64,
    parameter int VPN_BITS     = 36,
    parameter int PPN_BITS     = 44,
    parameter int EXTENDED_VPN = 64,
    parameter int EXTENDED_PPN = 64,
    parameter int OFFSET_BITS  = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    va_valid,
    input  logic [EXTENDED_VPN-1:0] va,
    output logic                    pa_valid,
    output logic [EXTENDED_PPN-1:0] pa,
    output tlb_perm_bits            pte_perm,
    output logic                    req_valid,
    output logic [EXTENDED_VPN-1:0] req_addr,
    input  logic                    resp_valid,
    input  logic [EXTENDED_PPN-1:0] resp_addr,
    input  tlb_perm_bits            resp_perm_bits,
    input  logic                    flush,
    input  logic                    flush_va_valid,
    input  logic [EXTENDED_VPN-1:0] flush_va,
    output logic                    busy
);

    localparam int LOG_SETS = $clog2(SETS);
    localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;

    tlb_entry_t          r_entries    [SETS][WAYS];
    logic [WAY_W-1:0]    r_victim_ptr [SETS];
    tlb_state_e          r_state;
    logic                r_req_valid;
    logic [EXTENDED_VPN-1:0] r_req_addr;
    logic [VPN_BITS-1:0] r_req_vpn;

    logic [VPN_BITS-1:0] w_va_tag;
    logic [LOG_SETS-1:0] w_va_set;
    logic [LOG_SETS-1:0] w_fill_set;
    tlb_entry_t          w_set_entries [WAYS];
    logic                w_hit;
    logic [WAY_W-1:0]    w_hit_way;
    tlb_entry_t          w_hit_entry;
    logic [WAY_W-1:0]    w_victim;
    logic                w_all_valid;
    logic                w_any_flush;
    logic                w_flush_all;
    logic                w_fill;
    logic                w_unused;

    assign w_va_tag    = va[VPN_BITS+OFFSET_BITS-1:OFFSET_BITS];
    assign w_va_set    = va[LOG_SETS+OFFSET_BITS-1:OFFSET_BITS];
    assign w_fill_set  = r_req_vpn[LOG_SETS-1:0];
    assign w_any_flush = flush | flush_va_valid;

`ifdef TLB_FLUSH_VA_EN
    logic [VPN_BITS-1:0] w_fva_tag;
    logic [LOG_SETS-1:0] w_fva_set;
    assign w_fva_tag   = flush_va[VPN_BITS+OFFSET_BITS-1:OFFSET_BITS];
    assign w_fva_set   = flush_va[LOG_SETS+OFFSET_BITS-1:OFFSET_BITS];
    assign w_flush_all = flush;
`else
    assign w_flush_all = flush | flush_va_valid;
`endif

    // A response only installs when no invalidation lands in the same cycle
    assign w_fill = (r_state == WAIT) && resp_valid && !w_any_flush;

    // Gather the ways of the addressed set for the lookup unit
    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            w_set_entries[w] = r_entries[w_va_set][w];
        end
    end

    tlb_set_lookup #(
        .WAYS  (WAYS),
        .WAY_W (WAY_W)
    ) u_lookup (
        .entries (w_set_entries),
        .tag     (TLB_VPN_W'(w_va_tag)),
        .hit     (w_hit),
        .way     (w_hit_way),
        .entry   (w_hit_entry)
    );

    assign pa_valid  = va_valid & w_hit;
    assign pa        = EXTENDED_PPN'({w_hit_entry.ppn[PPN_BITS-1:0], va[OFFSET_BITS-1:0]});
    assign pte_perm  = w_hit_entry.perm;
    assign req_valid = r_req_valid;
    assign req_addr  = r_req_addr;
    assign busy      = (r_state != IDLE);

    // Victim choice for the pending fill: lowest invalid way, else the round-robin pointer
    always_comb begin
        w_victim    = r_victim_ptr[w_fill_set];
        w_all_valid = 1'b1;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!r_entries[w_fill_set][i].valid) begin
                w_victim    = WAY_W'(i);
                w_all_valid = 1'b0;
            end
        end
    end

    // Entry array and victim pointers: invalidation takes priority over a fill
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SETS; s++) begin
                r_victim_ptr[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    r_entries[s][w] <= '0;
                end
            end
        end else if (w_flush_all) begin
            for (int s = 0; s < SETS; s++) begin
                r_victim_ptr[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    r_entries[s][w].valid <= 1'b0;
                end
            end
        end
`ifdef TLB_FLUSH_VA_EN
        else if (flush_va_valid) begin
            for (int w = 0; w < WAYS; w++) begin
                if (r_entries[w_fva_set][w].valid &&
                    (r_entries[w_fva_set][w].tag == TLB_VPN_W'(w_fva_tag))) begin
                    r_entries[w_fva_set][w].valid <= 1'b0;
                end
            end
        end
`endif
        else if (w_fill) begin
            r_entries[w_fill_set][w_victim].valid <= 1'b1;
            r_entries[w_fill_set][w_victim].tag   <= TLB_VPN_W'(r_req_vpn);
            r_entries[w_fill_set][w_victim].ppn   <= TLB_PPN_W'(resp_addr[PPN_BITS+OFFSET_BITS-1:OFFSET_BITS]);
            r_entries[w_fill_set][w_victim].perm  <= resp_perm_bits;
            if (w_all_valid) begin
                r_victim_ptr[w_fill_set] <= (r_victim_ptr[w_fill_set] == WAY_W'(WAYS - 1))
                                            ? '0 : r_victim_ptr[w_fill_set] + 1'b1;
            end
        end
    end

    // Miss controller: issue one request, hold it until the MMU answers, drop it if flushed
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_req_valid <= 1'b0;
            r_req_addr  <= '0;
            r_req_vpn   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (va_valid && !w_hit && !flush) begin
                        r_state     <= WAIT;
                        r_req_valid <= 1'b1;
                        r_req_addr  <= {va[EXTENDED_VPN-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                        r_req_vpn   <= w_va_tag;
                    end
                end
                WAIT: begin
                    if (w_any_flush) begin
                        if (resp_valid) begin
                            r_state     <= IDLE;
                            r_req_valid <= 1'b0;
                        end else begin
                            r_state <= DRAIN;
                        end
                    end else if (resp_valid) begin
                        r_state     <= IDLE;
                        r_req_valid <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (resp_valid) begin
                        r_state     <= IDLE;
                        r_req_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_valid <= 1'b0;
                end
            endcase
        end
    end

    // Bits that carry no information for this TLB (upper PA bits, offset, hit metadata)
    assign w_unused = ^{resp_addr[EXTENDED_PPN-1:PPN_BITS+OFFSET_BITS],
                        resp_addr[OFFSET_BITS-1:0], flush_va, w_hit_way,
                        w_hit_entry.valid, w_hit_entry.tag};

endmodule : set_assoc_tlb
`default_nettype wire

// File: tb/tb_set_assoc_tlb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_set_assoc_tlb                                           |
// | Description : Directed self-checking bench for set_assoc_tlb. Inputs    |
// |               change just after the falling edge; outputs are checked   |
// |               1 ns later, well away from the rising edge.               |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_set_assoc_tlb;
    import tlb_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         va_valid;
    logic [63:0]  va;
    logic         pa_valid;
    logic [63:0]  pa;
    tlb_perm_bits pte_perm;
    logic         req_valid;
    logic [63:0]  req_addr;
    logic         resp_valid;
    logic [63:0]  resp_addr;
    tlb_perm_bits resp_perm_bits;
    logic         flush;
    logic         flush_va_valid;
    logic [63:0]  flush_va;
    logic         busy;

    int checks   = 0;
    int failures = 0;
    tlb_perm_bits perm_rwx;

    always #5 clk = ~clk;

    set_assoc_tlb dut (
        .clk            (clk),
        .reset          (reset),
        .va_valid       (va_valid),
        .va             (va),
        .pa_valid       (pa_valid),
        .pa             (pa),
        .pte_perm       (pte_perm),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .resp_valid     (resp_valid),
        .resp_addr      (resp_addr),
        .resp_perm_bits (resp_perm_bits),
        .flush          (flush),
        .flush_va_valid (flush_va_valid),
        .flush_va       (flush_va),
        .busy           (busy)
    );

    task automatic tick;
        @(negedge clk);
    endtask

    // Install a page: the address must miss so the TLB requests it next cycle
    task automatic fill_page(input logic [63:0] v, input logic [63:0] p);
        va_valid = 1'b1; va = v; tick;
        va_valid = 1'b0; resp_valid = 1'b1; resp_addr = p; resp_perm_bits = perm_rwx; tick;
        resp_valid = 1'b0;
    endtask

    task automatic pulse_flush;
        flush = 1'b1; tick; flush = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0; va_valid = 1'b1; va = 64'h4000_1234;
        tick; tick; #1;
        checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got %b want 0", req_valid); end
        checks++; if (req_addr !== 64'h0) begin failures++; $display("FAIL reset_req_addr got %h want 0", req_addr); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (pa_valid !== 1'b0) begin failures++; $display("FAIL reset_pa_valid got %b want 0", pa_valid); end
        va_valid = 1'b0;
        tick; reset = 1'b1; tick;
    endtask

    task automatic test_basic_miss_fill;
        va_valid = 1'b1; va = 64'h4000_1234; #1;
        checks++; if (pa_valid !== 1'b0) begin failures++; $display("FAIL basic_first_miss got %b want 0", pa_valid); end
        tick; va_valid = 1'b0; #1;
        checks++; if (req_valid !== 1'b1) begin failures++; $display("FAIL basic_req_valid got %b want 1", req_valid); end
        checks++; if (req_addr !== 64'h4000_1000) begin failures++; $display("FAIL basic_req_addr got %h want 40001000", req_addr); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got %b want 1", busy); end
        resp_valid = 1'b1; resp_addr = 64'h8000_5000; resp_perm_bits = perm_rwx; tick;
        resp_valid = 1'b0; #1;
        checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL basic_req_drop got %b want 0", req_valid); end
        va_valid = 1'b1; va = 64'h4000_1234; #1;
        checks++; if (pa_valid !== 1'b1) begin failures++; $display("FAIL basic_hit got %b want 1", pa_valid); end
        checks++; if (pa !== 64'h8000_5234) begin failures++; $display("FAIL basic_pa got %h want 80005234", pa); end
        checks++; if (pte_perm !== perm_rwx) begin failures++; $display("FAIL basic_perm got %h want %h", pte_perm, perm_rwx); end
        va_valid = 1'b0; tick;
    endtask

    // Five pages in set 3 of a 4-way TLB: the fifth fill evicts way 0 (page 1)
    task automatic test_replacement;
        logic [63:0] v;
        pulse_flush;
        for (int k = 1; k <= 5; k++) begin
            v = 64'((k << 6) | 3) << 12;
            fill_page(v, 64'(32'h1000_0000 + (k << 12)));
        end
        va_valid = 1'b1; va = (64'((1 << 6) | 3) << 12) | 64'habc; #1;
        checks++; if (pa_valid !== 1'b0) begin failures++; $display("FAIL repl_evicted_page1 got %b want 0", pa_valid); end
        for (int k = 2; k <= 5; k++) begin
            va = (64'((k << 6) | 3) << 12) | 64'habc; #1;
            checks++; if (pa_valid !== 1'b1 || pa !== (64'(32'h1000_0000 + (k << 12)) | 64'habc)) begin
                failures++; $display("FAIL repl_page%0d_hit got v=%b pa=%h want v=1 pa=%h", k, pa_valid, pa,
                                     64'(32'h1000_0000 + (k << 12)) | 64'habc);
            end
        end
        va_valid = 1'b0; tick;
    endtask

    task automatic test_flush_in_wait;
        pulse_flush;
        va_valid = 1'b1; va = 64'h0000_7000; tick; va_valid = 1'b0;
        pulse_flush; #1;
        checks++; if (busy !== 1'b1 || req_valid !== 1'b1) begin failures++; $display("FAIL drain_hold got busy=%b req=%b want 1 1", busy, req_valid); end
        tick; #1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL drain_busy got %b want 1", busy); end
        resp_valid = 1'b1; resp_addr = 64'h9000_0000; tick; resp_valid = 1'b0; #1;
        checks++; if (busy !== 1'b0 || req_valid !== 1'b0) begin failures++; $display("FAIL drain_exit got busy=%b req=%b want 0 0", busy, req_valid); end
        va_valid = 1'b1; va = 64'h0000_7000; #1;
        checks++; if (pa_valid !== 1'b0) begin failures++; $display("FAIL drain_no_fill got %b want 0", pa_valid); end
        va_valid = 1'b0; tick;
    endtask

    task automatic test_flush_with_resp;
        pulse_flush;
        fill_page(64'h2000_3000, 64'hA000_0000);
        va_valid = 1'b1; va = 64'h2000_4000; tick;
        // Same cycle as the flush: lookup still sees pre-flush contents
        flush = 1'b1; resp_valid = 1'b1; resp_addr = 64'hB000_0000; va = 64'h2000_3010; #1;
        checks++; if (pa_valid !== 1'b1 || pa !== 64'hA000_0010) begin failures++; $display("FAIL preflush_hit got v=%b pa=%h want 1 a0000010", pa_valid, pa); end
        va_valid = 1'b0; tick; flush = 1'b0; resp_valid = 1'b0; #1;
        checks++; if (busy !== 1'b0 || req_valid !== 1'b0) begin failures++; $display("FAIL flushresp_idle got busy=%b req=%b want 0 0", busy, req_valid); end
        va_valid = 1'b1; va = 64'h2000_3000; #1;
        checks++; if (pa_valid !== 1'b0) begin failures++; $display("FAIL flushresp_a_gone got %b want 0", pa_valid); end
        va = 64'h2000_4000; #1;
        checks++; if (pa_valid !== 1'b0) begin failures++; $display("FAIL flushresp_b_not_filled got %b want 0", pa_valid); end
        va_valid = 1'b0; tick;
    endtask

    task automatic test_flush_va;
        logic exp_b;
`ifdef TLB_FLUSH_VA_EN
        exp_b = 1'b1;
`else
        exp_b = 1'b0;
`endif
        pulse_flush;
        fill_page(64'h3000_5000, 64'hC000_1000);
        fill_page(64'h3000_6000, 64'hC000_2000);
        flush_va_valid = 1'b1; flush_va = 64'h3000_5000; tick; flush_va_valid = 1'b0;
        va_valid = 1'b1; va = 64'h3000_5000; #1;
        checks++; if (pa_valid !== 1'b0) begin failures++; $display("FAIL flushva_a got %b want 0", pa_valid); end
        va = 64'h3000_6000; #1;
        checks++; if (pa_valid !== exp_b) begin failures++; $display("FAIL flushva_b got %b want %b", pa_valid, exp_b); end
        va_valid = 1'b0; tick;
    endtask

    task automatic test_hit_under_miss;
        pulse_flush;
        fill_page(64'h5000_1000, 64'hD000_0000);
        va_valid = 1'b1; va = 64'h5000_2000; tick;
        va = 64'h5000_1abc; #1;
        checks++; if (pa_valid !== 1'b1 || req_valid !== 1'b1) begin failures++; $display("FAIL hum_hit got v=%b req=%b want 1 1", pa_valid, req_valid); end
        checks++; if (pa !== 64'hD000_0abc) begin failures++; $display("FAIL hum_pa got %h want d0000abc", pa); end
        va_valid = 1'b0;
        #1 reset = 1'b0; #1;
        checks++; if (req_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL async_reset got req=%b busy=%b want 0 0", req_valid, busy); end
        tick; reset = 1'b1; tick;
        resp_valid = 1'b1; resp_addr = 64'hE000_0000; tick; resp_valid = 1'b0; #1;
        checks++; if (busy !== 1'b0 || req_valid !== 1'b0) begin failures++; $display("FAIL idle_resp_ignored got busy=%b req=%b want 0 0", busy, req_valid); end
        tick;
    endtask

    initial begin
        perm_rwx = '0;
        perm_rwx.v = 1'b1; perm_rwx.r = 1'b1; perm_rwx.w = 1'b1; perm_rwx.x = 1'b1;
        reset = 1'b0; va_valid = 1'b0; va = '0; resp_valid = 1'b0; resp_addr = '0;
        resp_perm_bits = '0; flush = 1'b0; flush_va_valid = 1'b0; flush_va = '0;
        tick;
        test_reset;
        test_basic_miss_fill;
        test_replacement;
        test_flush_in_wait;
        test_flush_with_resp;
        test_flush_va;
        test_hit_under_miss;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule : tb_set_assoc_tlb
`default_nettype wire
